// File: rtl/iob_cache_write_channel_axi_burst.sv
// AXI4 write channel issuing one INCR burst per accepted request, with AW and W running concurrently.
// Optional retry on B-channel error responses is enabled by defining IOB_CACHE_AXI_RETRY_EN.
module iob_cache_write_channel_axi_burst #(
    parameter int BE_ADDR_W   = 32,
    parameter int BE_DATA_W   = 32,
    parameter int MAX_BEATS_W = 2,
    parameter int AXI_ID_W    = 1,
    parameter int AXI_ID      = 0,
    parameter int MAX_RETRY   = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic                                   valid,
    input  logic [BE_ADDR_W-1:0]                   addr,
    input  logic [((MAX_BEATS_W > 0) ? MAX_BEATS_W : 1)-1:0] len,
    input  logic [BE_DATA_W*(2**MAX_BEATS_W)-1:0]  wdata,
    input  logic [BE_DATA_W/8-1:0]                 wstrb,
    output logic                                   ready,
    output logic                                   done,
    output logic                                   error,

    output logic                                   axi_awvalid,
    input  logic                                   axi_awready,
    output logic [BE_ADDR_W-1:0]                   axi_awaddr,
    output logic [7:0]                             axi_awlen,
    output logic [2:0]                             axi_awsize,
    output logic [1:0]                             axi_awburst,
    output logic [0:0]                             axi_awlock,
    output logic [3:0]                             axi_awcache,
    output logic [2:0]                             axi_awprot,
    output logic [3:0]                             axi_awqos,
    output logic [AXI_ID_W-1:0]                    axi_awid,

    output logic                                   axi_wvalid,
    input  logic                                   axi_wready,
    output logic [BE_DATA_W-1:0]                   axi_wdata,
    output logic [BE_DATA_W/8-1:0]                 axi_wstrb,
    output logic                                   axi_wlast,

    input  logic                                   axi_bvalid,
    input  logic [1:0]                             axi_bresp,
    output logic                                   axi_bready
);

    localparam int LEN_W    = (MAX_BEATS_W > 0) ? MAX_BEATS_W : 1;
    localparam int STRB_W   = BE_DATA_W / 8;
    localparam int OFFSET_W = $clog2(STRB_W);
    localparam int LINE_W   = BE_DATA_W * (2 ** MAX_BEATS_W);
    localparam logic [BE_ADDR_W-1:0] ADDR_MASK = {BE_ADDR_W{1'b1}} << OFFSET_W;

`ifdef IOB_CACHE_AXI_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    logic [BE_ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [LINE_W-1:0]    line_reg;
    logic [STRB_W-1:0]    strb_reg;
    logic [LEN_W-1:0]     beat;
    logic                 aw_done;
    logic                 w_done;

    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign axi_awaddr  = addr_reg;
    assign axi_awlen   = 8'(len_reg);
    assign axi_awsize  = 3'(OFFSET_W);
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot  = 3'b000;
    assign axi_awqos   = 4'b0000;
    assign axi_awid    = AXI_ID_W'(AXI_ID);

    assign axi_wdata = line_reg[beat*BE_DATA_W +: BE_DATA_W];
    assign axi_wstrb = strb_reg;
    assign axi_wlast = (beat == len_reg);

    // A channel counts as finished either from an earlier handshake or one landing this cycle,
    // so AW and the last W beat may complete in either order or together.
    assign aw_hs  = axi_awvalid & axi_awready;
    assign w_hs   = axi_wvalid & axi_wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | (w_hs & axi_wlast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            addr_reg    <= '0;
            len_reg     <= '0;
            line_reg    <= '0;
            strb_reg    <= '0;
            beat        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
`ifdef IOB_CACHE_AXI_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        addr_reg    <= addr & ADDR_MASK;
                        len_reg     <= len;
                        line_reg    <= wdata;
                        strb_reg    <= wstrb;
                        beat        <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        ready       <= 1'b0;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
`ifdef IOB_CACHE_AXI_RETRY_EN
                        retry_cnt   <= '0;
`endif
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        if (axi_wlast) begin
                            axi_wvalid <= 1'b0;
                            w_done     <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    if (aw_fin && w_fin) begin
                        axi_bready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp == 2'b00) begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
`ifdef IOB_CACHE_AXI_RETRY_EN
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt   <= retry_cnt + 1'b1;
                                beat        <= '0;
                                aw_done     <= 1'b0;
                                w_done      <= 1'b0;
                                axi_awvalid <= 1'b1;
                                axi_wvalid  <= 1'b1;
                                state       <= XFER;
                            end else begin
                                done  <= 1'b1;
                                error <= 1'b1;
                                ready <= 1'b1;
                                state <= IDLE;
                            end
`else
                            done  <= 1'b1;
                            error <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: begin
                    ready       <= 1'b1;
                    axi_awvalid <= 1'b0;
                    axi_wvalid  <= 1'b0;
                    axi_bready  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/iob_cache_write_channel_axi_burst.md
Name: iob_cache_write_channel_axi_burst

Overview:
- Next-generation AXI4 write channel for the cache back-end.
- Accepts one request per transaction: a base address, a variable burst length and a captured line of back-end words, then issues a single INCR burst on AXI.
- Runs AW and W concurrently; W beats may be sent before the AW handshake completes.
- Reports completion and error status per transaction, and can optionally retry on error responses.
- Sits between the cache write-back/write-through logic and the AXI interconnect.

Parameters:
- BE_ADDR_W, 32: AXI address width.
- BE_DATA_W, 32: AXI data width; power of 2, minimum 8.
- MAX_BEATS_W, 2: log2 of maximum burst beats; max burst is 2**MAX_BEATS_W beats, allowed range 0..8.
- AXI_ID_W, 1: AXI ID width.
- AXI_ID, 0: constant value driven on axi_awid.
- MAX_RETRY, 3: maximum re-transfers after error responses; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  request valid
- addr  in  BE_ADDR_W  burst base address; low log2(BE_DATA_W/8) bits are ignored and forced to zero
- len  in  max(MAX_BEATS_W,1)  beats minus one
- wdata  in  BE_DATA_W*2**MAX_BEATS_W  line data; beat k is wdata[k*BE_DATA_W +: BE_DATA_W]
- wstrb  in  BE_DATA_W/8  byte strobe, applied to every beat
- ready  out  1  request accepted when valid & ready
- done  out  1  one-cycle pulse at transaction end
- error  out  1  qualifies done; high means the transaction failed
- axi_awvalid/awready, axi_awaddr[BE_ADDR_W], axi_awlen[8], axi_awsize[3], axi_awburst[2], axi_awlock[1], axi_awcache[4], axi_awprot[3], axi_awqos[4], axi_awid[AXI_ID_W]  AW channel
- axi_wvalid/wready, axi_wdata[BE_DATA_W], axi_wstrb[BE_DATA_W/8], axi_wlast  W channel
- axi_bvalid, axi_bresp[2], axi_bready  B channel

Behaviour:
- Constant AXI fields:
  - awburst=2'b01 (INCR), awsize=log2(BE_DATA_W/8), awlock=0, awcache=4'b0011, awprot=0, awqos=0, awid=AXI_ID.
  - awlen = len_reg zero-extended to 8 bits.
- Reset values: state=IDLE, ready=1, awvalid=0, wvalid=0, bready=0, done=0, error=0, beat counter=0, retry counter=0.
- IDLE:
  - ready=1.
  - On valid, register addr, len, wdata and wstrb, then go to XFER on the next cycle.
  - ready drops the cycle after acceptance, so there is no back-to-back acceptance.
- XFER:
  - axi_awvalid is held until the AW handshake, then cleared (aw_done flag set).
  - axi_wvalid is held until the last W handshake.
  - axi_wdata = beat slice selected by the beat counter.
  - axi_wlast = (beat == len_reg).
  - The beat counter increments on each wvalid & wready.
  - AW and W are independent: either may complete first, and both may complete in the same cycle.
  - Exit to RESP in the cycle after both the AW handshake and the last-beat W handshake have happened.
- RESP:
  - bready=1.
  - bvalid with bresp==OKAY (2'b00): go to IDLE and assert done=1, error=0 for one cycle.
  - bvalid with any other bresp: behaviour is set by the optional feature.
  - valid is ignored outside IDLE.
- len=0 gives a single beat with wlast on beat 0.
- Payload and strobe are stable from acceptance to done, including across retries.
- Reset asserted mid-transfer returns the block to IDLE next cycle and drops all valids; the in-flight AXI transaction is abandoned.
- Outputs ready, awvalid, wvalid and bready are driven from registers or state only, with no combinational path from AXI inputs.

Optional Feature:
- Macro: IOB_CACHE_AXI_RETRY_EN.
- Defined:
  - A B-channel error while retry_cnt < MAX_RETRY increments retry_cnt.
  - The beat counter and aw_done are cleared and the block returns to XFER, re-issuing the same burst.
  - An error at retry_cnt == MAX_RETRY ends the transaction with done=1, error=1.
  - retry_cnt is cleared on every new acceptance.
- Undefined:
  - Any error response immediately ends the transaction with done=1, error=1 and returns to IDLE.
  - No retry counter exists.

Test Plan:
- len=3, wdata beats 0xA0..0xA3, awready/wready tied 1, bresp=OKAY -> awlen=3, four W beats in order with wlast only on 0xA3, awaddr low bits zeroed, then done=1, error=0 for one cycle.
- awready held low 5 cycles, wready=1 -> all W beats complete first, AW completes later, RESP entered only after AW, data unchanged.
- len=0, wstrb=4'b0010 -> single beat, wlast=1, axi_wstrb=4'b0010, awburst=01.
- bresp=2'b10 once, then OKAY -> with IOB_CACHE_AXI_RETRY_EN: AW plus all beats repeated, final done=1, error=0. Without the macro: done=1, error=1 after the first response.
- Retry enabled, MAX_RETRY=3, bresp always 2'b10 -> exactly 4 bursts issued, then done=1, error=1.
- Reset asserted during beat 2 of 4 -> next cycle IDLE, ready=1, awvalid=wvalid=bready=0; a new request then completes normally.
